// File: rtl/set_ctl.sv
// ---------------------------------------------------------------------------
// set_ctl -- slow-peripheral settings register with guarded, deferred update.
//
// A settings-space write (BACT && SetCSWR) carries a configuration word on the
// address lines. The word is staged in a shadow register. It is applied only
// once the bus is sampled idle, so the slowdown controls never change in the
// middle of a bus cycle.
//
// Build option (define the macro to enable it):
//   SET_LOCK_EN  The configuration write must be preceded by a key write
//                (A == KEY) that arms the block for ARM_WIN cycles. When the
//                macro is not defined, any write is staged directly, there is
//                no key check, and Armed is tied low.
//
// Ports:
//   CLK          in   system clock; all state changes on the rising edge
//   nPOR         in   asynchronous active-low reset
//   BACT         in   bus cycle active
//   A[AW:1]      in   address lines carrying the config word (AW = NCH+TW)
//   SetCSWR      in   settings-space write select
//   SlowEn       out  per-channel slow enables; A[NCH:1] -> SlowEn[NCH-1:0]
//   SlowTimeout  out  slow timeout field; A[AW:NCH+1]
//   CfgStrobe    out  one-cycle pulse on the cycle new settings take effect
//   Armed        out  high while the block is armed by a key write
//   Reject       out  one-cycle pulse when a write is discarded
// ---------------------------------------------------------------------------
module set_ctl #(
  parameter int              NCH     = 7,
  parameter int              TW      = 4,
  parameter logic [TW-1:0]   TO_RST  = 4'd3,
  parameter logic [NCH-1:0]  EN_RST  = '1,
  parameter logic [NCH+TW-1:0] KEY   = 11'h5A5,
  parameter int              ARM_WIN = 15
) (
  input  logic              CLK,
  input  logic              nPOR,
  input  logic              BACT,
  input  logic [NCH+TW:1]   A,
  input  logic              SetCSWR,
  output logic [NCH-1:0]    SlowEn,
  output logic [TW-1:0]     SlowTimeout,
  output logic              CfgStrobe,
  output logic              Armed,
  output logic              Reject
);

  localparam int AW = NCH + TW;

  // Elaboration-time guard on the parameter ranges.
  if (ARM_WIN < 1 || ARM_WIN > 65535 || KEY > {AW{1'b1}}) begin : g_bad_param
    $error("set_ctl: ARM_WIN must be 1..65535 and KEY must fit in AW bits");
  end

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_ARMED  = 2'd1,
    ST_PEND   = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Request capture: one event per bus cycle, however long the strobe is.
  // -------------------------------------------------------------------------
  logic          wr_req_q;
  logic          wr_req_dly_q;
  logic [AW:1]   ar_q;
  logic          wr_pulse;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      wr_req_q     <= 1'b0;
      wr_req_dly_q <= 1'b0;
      ar_q         <= '0;
    end else begin
      wr_req_q     <= BACT && SetCSWR;
      wr_req_dly_q <= wr_req_q;
      // Latch the address only on the first sampled edge of the write.
      if (BACT && SetCSWR && !wr_req_q) begin
        ar_q <= A;
      end
    end
  end

  assign wr_pulse = wr_req_q && !wr_req_dly_q;

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  state_e          state_q,   state_d;
  logic [AW:1]     shadow_q,  shadow_d;
  logic [NCH-1:0]  slow_en_q, slow_en_d;
  logic [TW-1:0]   timeout_q, timeout_d;
  logic            strobe_q,  strobe_d;
  logic            reject_q,  reject_d;

`ifdef SET_LOCK_EN
  localparam int            CW        = $clog2(ARM_WIN + 1);
  localparam logic [CW-1:0] ARM_WIN_C = CW'(ARM_WIN);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q;
  logic          key_hit;

  assign key_hit = (ar_q == KEY);
`endif

  // NOTE: every always_comb output gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    slow_en_d = slow_en_q;
    timeout_d = timeout_q;
    strobe_d  = 1'b0;
    reject_d  = 1'b0;
`ifdef SET_LOCK_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_LOCKED: begin
        if (wr_pulse) begin
`ifdef SET_LOCK_EN
          if (key_hit) begin
            state_d = ST_ARMED;
            cnt_d   = ARM_WIN_C;
          end else begin
            reject_d = 1'b1;
          end
`else
          shadow_d = ar_q;
          state_d  = ST_PEND;
`endif
        end
      end

`ifdef SET_LOCK_EN
      ST_ARMED: begin
        // A write takes priority over window expiry in the same cycle.
        if (wr_pulse) begin
          if (key_hit) begin
            cnt_d = ARM_WIN_C;
          end else begin
            shadow_d = ar_q;
            cnt_d    = '0;
            state_d  = ST_PEND;
          end
        end else if (cnt_q <= CW'(1)) begin
          // The count is about to reach zero: disarm silently, no wrap.
          cnt_d   = '0;
          state_d = ST_LOCKED;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif

      ST_PEND: begin
        // Writes while a config is pending are dropped; the shadow is kept.
        if (wr_pulse) begin
          reject_d = 1'b1;
        end
        if (!BACT) begin
          slow_en_d = shadow_q[NCH:1];
          timeout_d = shadow_q[AW:NCH+1];
          strobe_d  = 1'b1;
          state_d   = ST_LOCKED;
        end
      end

      default: state_d = ST_LOCKED;
    endcase
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q   <= ST_LOCKED;
      shadow_q  <= '0;
      slow_en_q <= EN_RST;
      timeout_q <= TO_RST;
      strobe_q  <= 1'b0;
      reject_q  <= 1'b0;
`ifdef SET_LOCK_EN
      cnt_q     <= '0;
      armed_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      slow_en_q <= slow_en_d;
      timeout_q <= timeout_d;
      strobe_q  <= strobe_d;
      reject_q  <= reject_d;
`ifdef SET_LOCK_EN
      cnt_q     <= cnt_d;
      armed_q   <= (state_d == ST_ARMED);
`endif
    end
  end

  assign SlowEn      = slow_en_q;
  assign SlowTimeout = timeout_q;
  assign CfgStrobe   = strobe_q;
  assign Reject      = reject_q;
`ifdef SET_LOCK_EN
  assign Armed       = armed_q;
`else
  assign Armed       = 1'b0;
`endif

endmodule
